// File: rtl/level_tone_gen.sv
// level_tone_gen: plays a fixed-length square-wave tone whose amplitude is
// selected by a 0..9 level code, and streams the samples to an audio-out FIFO.
// Codes 10..15 are rejected with a one-cycle level_err pulse.
module level_tone_gen #(
    parameter int HALF_PERIOD = 56818,
    parameter int TONE_CYCLES = 25000000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [3:0]         level,
    input  logic               level_valid,
    input  logic               audio_out_allowed,
    output logic               write_audio_out,
    output logic signed [31:0] left_channel_audio_out,
    output logic signed [31:0] right_channel_audio_out,
    output logic               busy,
    output logic               done,
    output logic               level_err
);

    localparam int HALF_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int DUR_W  = (TONE_CYCLES > 1) ? $clog2(TONE_CYCLES) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_PERIOD - 1);
    localparam logic [DUR_W-1:0]  DUR_LAST  = DUR_W'(TONE_CYCLES - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t             state;
    logic [3:0]         cur_level;
    logic [DUR_W-1:0]   dur_cnt;
    logic [HALF_W-1:0]  half_cnt;
    logic               phase;
    logic signed [31:0] sample;

    logic               code_ok;
    logic               code_bad;
    logic               phase_next;
    logic signed [31:0] amp_sel;

    // Level code to square-wave amplitude.
    function automatic logic signed [31:0] level_amp(input logic [3:0] code);
        case (code)
            4'd0:    level_amp = 32'sd0;
            4'd1:    level_amp = 32'sd600000;
            4'd2:    level_amp = 32'sd2400000;
            4'd3:    level_amp = 32'sd3900000;
            4'd4:    level_amp = 32'sd8000000;
            4'd5:    level_amp = 32'sd40000000;
            4'd6:    level_amp = 32'sd110000000;
            4'd7:    level_amp = 32'sd300000000;
            4'd8:    level_amp = 32'sd700000000;
            4'd9:    level_amp = 32'sd1100000000;
            // NOTE: the default arm keeps the decode fully specified, so using
            // it in combinational logic can never infer a latch.
            default: level_amp = 32'sd0;
        endcase
    endfunction

    assign code_ok  = level_valid && (level <= 4'd9);
    assign code_bad = level_valid && (level > 4'd9);

    // Phase that will hold after this edge while playing; the sample register
    // is loaded from it so the output lines up with the registered phase.
    assign phase_next = (half_cnt == HALF_LAST) ? ~phase : phase;

    // A retrigger switches amplitude on the same edge it is accepted.
    assign amp_sel = level_amp(code_ok ? level : cur_level);

    // Tone FSM: start/retrigger, square-wave timing, duration and pulses.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: reset is synchronous and clears every register here; all
        // state uses non-blocking assignments so each register sees the
        // pre-edge values of the others.
        if (reset) begin
            state     <= IDLE;
            cur_level <= '0;
            dur_cnt   <= '0;
            half_cnt  <= '0;
            phase     <= 1'b1;
            sample    <= '0;
            done      <= 1'b0;
            level_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            level_err <= code_bad;
            case (state)
                IDLE: begin
                    if (code_ok) begin
                        cur_level <= level;
                        dur_cnt   <= DUR_LAST;
                        half_cnt  <= '0;
                        phase     <= 1'b1;
                        sample    <= amp_sel;
                        state     <= PLAY;
                    end else begin
                        sample    <= '0;
                    end
                end
                PLAY: begin
                    half_cnt <= (half_cnt == HALF_LAST) ? '0 : half_cnt + HALF_W'(1);
                    phase    <= phase_next;
                    if (code_ok) begin
                        cur_level <= level;
                        dur_cnt   <= DUR_LAST;
                        sample    <= phase_next ? amp_sel : -amp_sel;
                    end else if (dur_cnt == '0) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        sample    <= '0;
                    end else begin
                        dur_cnt   <= dur_cnt - DUR_W'(1);
                        sample    <= phase_next ? amp_sel : -amp_sel;
                    end
                end
            endcase
        end
    end

    // The FIFO is fed every cycle it has room, so it never starves.
    assign write_audio_out         = audio_out_allowed & ~reset;
    assign left_channel_audio_out  = sample;
    assign right_channel_audio_out = sample;
    assign busy                    = (state == PLAY);

endmodule

// File: tb/tb_level_tone_gen.sv
// tb_level_tone_gen: table-driven vectors for a level-5 tone and an invalid
// code, then model-driven sequences for retrigger, reset and handshake cases.
module tb_level_tone_gen;

    localparam int HP = 4;
    localparam int TC = 20;

    logic               CLOCK_50;
    logic               reset;
    logic [3:0]         level;
    logic               level_valid;
    logic               audio_out_allowed;
    logic               write_audio_out;
    logic signed [31:0] left_channel_audio_out;
    logic signed [31:0] right_channel_audio_out;
    logic               busy;
    logic               done;
    logic               level_err;

    level_tone_gen #(
        .HALF_PERIOD(HP),
        .TONE_CYCLES(TC)
    ) dut (
        .CLOCK_50               (CLOCK_50),
        .reset                  (reset),
        .level                  (level),
        .level_valid            (level_valid),
        .audio_out_allowed      (audio_out_allowed),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .busy                   (busy),
        .done                   (done),
        .level_err              (level_err)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic               rst;
        logic               vld;
        logic [3:0]         lvl;
        logic               busy;
        logic signed [31:0] samp;
        logic               done;
        logic               err;
    } vec_t;

    typedef struct {
        logic               busy;
        logic signed [31:0] samp;
        logic               done;
        logic               err;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   busy_cycles = 0;
    int   done_cnt = 0;
    exp_t sb_q[$];
    vec_t tbl[$];

    int amp_tbl [0:9] = '{0, 600000, 2400000, 3900000, 8000000,
                          40000000, 110000000, 300000000, 700000000, 1100000000};

    // Reference model: position since tone start and remaining PLAY cycles.
    logic m_busy = 1'b0;
    int   m_rem  = 0;
    int   m_pos  = 0;
    int   m_lvl  = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] l,
                                input logic b, input logic signed [31:0] s,
                                input logic d, input logic e);
        vec_t t;
        t.rst = r; t.vld = v; t.lvl = l; t.busy = b; t.samp = s; t.done = d; t.err = e;
        return t;
    endfunction

    // Drive one cycle, queue its expectation, compare after the edge.
    task automatic step(input logic r, input logic v, input logic [3:0] l,
                        input logic a, input exp_t e);
        exp_t got;
        reset = r; level_valid = v; level = l; audio_out_allowed = a;
        sb_q.push_back(e);
        #1;
        check("write_audio_out", 32'(write_audio_out), 32'(a & ~r));
        @(posedge CLOCK_50);
        #1;
        got = sb_q.pop_front();
        check("busy",      32'(busy),      32'(got.busy));
        check("done",      32'(done),      32'(got.done));
        check("level_err", 32'(level_err), 32'(got.err));
        check("left",      left_channel_audio_out,  got.samp);
        check("right",     right_channel_audio_out, got.samp);
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic model_step(input logic r, input logic v, input logic [3:0] l,
                              output exp_t e);
        e.done = 1'b0;
        e.err  = !r && v && (l > 4'd9);
        if (r) begin
            m_busy = 1'b0;
            m_lvl  = 0;
        end else if (v && l <= 4'd9) begin
            if (!m_busy) begin
                m_busy = 1'b1;
                m_pos  = 0;
            end else begin
                m_pos++;
            end
            m_lvl = int'(l);
            m_rem = TC - 1;
        end else if (m_busy) begin
            if (m_rem == 0) begin
                m_busy = 1'b0;
                e.done = 1'b1;
            end else begin
                m_rem--;
                m_pos++;
            end
        end
        e.busy = m_busy;
        if (!m_busy)
            e.samp = 0;
        else
            e.samp = (((m_pos / HP) % 2) == 0) ? amp_tbl[m_lvl] : -amp_tbl[m_lvl];
    endtask

    task automatic run(input logic r, input logic v, input logic [3:0] l);
        exp_t e;
        logic a;
        a = 1'($urandom_range(0, 1));
        model_step(r, v, l, e);
        step(r, v, l, a, e);
    endtask

    task automatic clear_counts();
        busy_cycles = 0;
        done_cnt    = 0;
    endtask

    initial begin
        logic signed [31:0] pos5;
        logic signed [31:0] neg5;
        exp_t e;
        pos5 = 32'sd40000000;
        neg5 = -32'sd40000000;

        reset = 1'b1; level = '0; level_valid = 1'b0; audio_out_allowed = 1'b1;

        // Level-5 tone: +A for 4 clocks, -A for 4, done after 20 PLAY clocks,
        // then an invalid code in IDLE.
        tbl.push_back(mk(1, 0, 4'd0,  0, 0,    0, 0));
        tbl.push_back(mk(0, 1, 4'd5,  1, pos5, 0, 0));
        repeat (3) tbl.push_back(mk(0, 0, 4'd0, 1, pos5, 0, 0));
        repeat (4) tbl.push_back(mk(0, 0, 4'd0, 1, neg5, 0, 0));
        repeat (4) tbl.push_back(mk(0, 0, 4'd0, 1, pos5, 0, 0));
        repeat (4) tbl.push_back(mk(0, 0, 4'd0, 1, neg5, 0, 0));
        repeat (4) tbl.push_back(mk(0, 0, 4'd0, 1, pos5, 0, 0));
        tbl.push_back(mk(0, 0, 4'd0,  0, 0,    1, 0));
        tbl.push_back(mk(0, 1, 4'd12, 0, 0,    0, 1));
        tbl.push_back(mk(0, 0, 4'd0,  0, 0,    0, 0));

        clear_counts();
        for (int i = 0; i < tbl.size(); i++) begin
            e.busy = tbl[i].busy; e.samp = tbl[i].samp;
            e.done = tbl[i].done; e.err  = tbl[i].err;
            step(tbl[i].rst, tbl[i].vld, tbl[i].lvl, 1'b1, e);
        end
        check("table_done_count", 32'(done_cnt), 32'd1);

        // Model-driven sequences with random FIFO back-pressure.
        run(1, 0, 4'd0);
        run(1, 0, 4'd0);

        // Level 0 is a real, silent tone.
        clear_counts();
        run(0, 1, 4'd0);
        repeat (22) run(0, 0, 4'd0);
        check("lvl0_busy_len", 32'(busy_cycles), 32'd20);
        check("lvl0_done_cnt", 32'(done_cnt), 32'd1);

        // Invalid code in IDLE, then in the middle of a tone.
        clear_counts();
        run(0, 1, 4'd12);
        run(0, 0, 4'd0);
        run(0, 1, 4'd3);
        repeat (5) run(0, 0, 4'd0);
        run(0, 1, 4'd15);
        repeat (17) run(0, 0, 4'd0);
        check("bad_busy_len", 32'(busy_cycles), 32'd20);
        check("bad_done_cnt", 32'(done_cnt), 32'd1);

        // Retrigger 10 clocks after the start.
        clear_counts();
        run(0, 1, 4'd9);
        repeat (9) run(0, 0, 4'd0);
        run(0, 1, 4'd2);
        repeat (24) run(0, 0, 4'd0);
        check("retrig_busy_len", 32'(busy_cycles), 32'd30);
        check("retrig_done_cnt", 32'(done_cnt), 32'd1);

        // Reset 7 clocks into PLAY, with a strobe that must be ignored.
        clear_counts();
        run(0, 1, 4'd7);
        repeat (6) run(0, 0, 4'd0);
        run(1, 1, 4'd4);
        run(1, 0, 4'd0);
        repeat (3) run(0, 0, 4'd0);
        check("rst_busy_len", 32'(busy_cycles), 32'd7);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);

        // Retrigger in the terminal cycle.
        clear_counts();
        run(0, 1, 4'd1);
        repeat (19) run(0, 0, 4'd0);
        run(0, 1, 4'd8);
        repeat (22) run(0, 0, 4'd0);
        check("term_busy_len", 32'(busy_cycles), 32'd40);
        check("term_done_cnt", 32'(done_cnt), 32'd1);

        // Longer stretch with random retriggers and codes.
        for (int i = 0; i < 60; i++) begin
            logic v;
            logic [3:0] l;
            v = ($urandom_range(0, 9) == 0);
            l = 4'($urandom_range(0, 15));
            run(0, v, l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
